// File: rtl/rr_request_queue_if.sv
// rtl/rr_request_queue_if.sv - consumer-side and scheduler-side handshake bundle for rr_request_queue
interface rr_request_queue_if #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int DEPTH       = 4
);
  localparam int REQ_WIDTH = ADDR_WIDTH + VALUE_WIDTH + 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic                   in_valid;
  logic                   in_ready;
  logic                   in_we;
  logic [ADDR_WIDTH-1:0]  in_addr;
  logic [VALUE_WIDTH-1:0] in_value;
  logic [REQ_WIDTH-1:0]   request;
  logic                   grant;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   empty;
  logic                   err_grant;

  modport master (
    output in_valid, in_we, in_addr, in_value, grant,
    input  in_ready, request, count, full, empty, err_grant
  );

  modport slave (
    input  in_valid, in_we, in_addr, in_value, grant,
    output in_ready, request, count, full, empty, err_grant
  );
endinterface

// File: rtl/rr_request_queue.sv
// rtl/rr_request_queue.sv - per-consumer request FIFO feeding one round-robin scheduler input
// Optional zero-latency empty-queue bypass under macro RR_REQ_QUEUE_BYPASS_EN.
module rr_request_queue #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int DEPTH       = 4
) (
  input  logic              clk,
  input  logic              reset,
  rr_request_queue_if.slave q
);
  localparam int REQ_WIDTH = ADDR_WIDTH + VALUE_WIDTH + 2;
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int PW        = $clog2(DEPTH);
  localparam int EW        = REQ_WIDTH - 1;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 err_q, err_d;
  logic                 head_valid, full_w;
  logic                 push, pop, bypass_take, store, drain;
  logic [REQ_WIDTH-1:0] request_w;

  assign head_valid = (count_q != '0);
  assign full_w     = (count_q == CW'(DEPTH));

  always_comb begin
    // Whole word is forced to zero when empty so the scheduler can OR queues together.
    request_w   = head_valid ? {1'b1, mem_q[rd_ptr_q]} : '0;
    bypass_take = 1'b0;
`ifdef RR_REQ_QUEUE_BYPASS_EN
    if (!head_valid && q.in_valid) begin
      request_w = {1'b1, q.in_we, q.in_addr, q.in_value};
    end
`endif
    push = q.in_valid & ~full_w;
    pop  = q.grant & request_w[REQ_WIDTH-1];
`ifdef RR_REQ_QUEUE_BYPASS_EN
    bypass_take = ~head_valid & push & q.grant;
`endif
    store = push & ~bypass_take;
    drain = pop & ~bypass_take;

    wr_ptr_d = store ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = drain ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({store, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    err_d = err_q | (q.grant & ~request_w[REQ_WIDTH-1]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately left out of reset; count_q alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= {q.in_we, q.in_addr, q.in_value};
    end
  end

  assign q.request   = request_w;
  assign q.in_ready  = ~full_w;
  assign q.full      = full_w;
  assign q.empty     = ~head_valid;
  assign q.count     = count_q;
  assign q.err_grant = err_q;
endmodule

// File: tb/tb_rr_request_queue.sv
// tb/tb_rr_request_queue.sv - directed self-checking bench for rr_request_queue
module tb_rr_request_queue;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rr_request_queue_if #(.ADDR_WIDTH(4), .VALUE_WIDTH(8), .DEPTH(4)) bus ();

  rr_request_queue #(.ADDR_WIDTH(4), .VALUE_WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  function automatic logic [13:0] mk(input logic we, input logic [3:0] a, input logic [7:0] v);
    return {1'b1, we, a, v};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic we, input logic [3:0] a, input logic [7:0] v);
    bus.in_valid = vld;
    bus.in_we    = we;
    bus.in_addr  = a;
    bus.in_value = v;
  endtask

  task automatic push(input logic we, input logic [3:0] a, input logic [7:0] v);
    drive(1'b1, we, a, v);
    tick;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reset;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.grant = 1'b0;
    drive(1'b1, 1'b1, 4'd1, 8'h22);
    repeat (3) tick;
    total++; if (bus.request !== 14'h0) begin bad++; $display("FAIL reset_request got=%h want=0", bus.request); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", bus.full); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
    total++; if (bus.err_grant !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err_grant); end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL reset_no_push got=%0d want=0", bus.count); end
  endtask

  task automatic test_order;
    logic [13:0] exp [3];
    exp[0] = mk(1'b1, 4'd3, 8'h5A);
    exp[1] = mk(1'b0, 4'd7, 8'h00);
    exp[2] = mk(1'b1, 4'd15, 8'hFF);
    push(1'b1, 4'd3, 8'h5A);
    #1;
    total++; if (bus.request !== exp[0]) begin bad++; $display("FAIL order_latency got=%h want=%h", bus.request, exp[0]); end
    push(1'b0, 4'd7, 8'h00);
    push(1'b1, 4'd15, 8'hFF);
    #1;
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL order_count got=%0d want=3", bus.count); end
    bus.grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.request !== exp[i]) begin bad++; $display("FAIL order_head%0d got=%h want=%h", i, bus.request, exp[i]); end
      tick;
    end
    bus.grant = 1'b0;
    #1;
    total++; if (bus.request !== 14'h0) begin bad++; $display("FAIL order_drained got=%h want=0", bus.request); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL order_empty got=%b want=1", bus.empty); end
  endtask

  task automatic test_full_wrap;
    logic [13:0] exp [4];
    pulse_reset;
    push(1'b1, 4'd1, 8'h01);
    push(1'b0, 4'd2, 8'h00);
    push(1'b1, 4'd4, 8'h44);
    push(1'b1, 4'd8, 8'h88);
    #1;
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", bus.full); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", bus.count); end
    drive(1'b1, 1'b1, 4'd12, 8'hCC);
    tick;
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL full_held got=%0d want=4", bus.count); end
    bus.grant = 1'b1;
    #1;
    total++; if (bus.request !== mk(1'b1, 4'd1, 8'h01)) begin bad++; $display("FAIL full_head got=%h want=%h", bus.request, mk(1'b1, 4'd1, 8'h01)); end
    tick;
    total++; if (bus.count !== 3'd3) begin bad++; $display("FAIL full_pop_refuse got=%0d want=3", bus.count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop got=%b want=1", bus.in_ready); end
    bus.grant = 1'b0;
    tick;
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.count !== 3'd4) begin bad++; $display("FAIL wrap_push got=%0d want=4", bus.count); end
    exp[0] = mk(1'b0, 4'd2, 8'h00);
    exp[1] = mk(1'b1, 4'd4, 8'h44);
    exp[2] = mk(1'b1, 4'd8, 8'h88);
    exp[3] = mk(1'b1, 4'd12, 8'hCC);
    bus.grant = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (bus.request !== exp[i]) begin bad++; $display("FAIL wrap_head%0d got=%h want=%h", i, bus.request, exp[i]); end
      tick;
    end
    bus.grant = 1'b0;
    #1;
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b want=1", bus.empty); end
  endtask

  task automatic test_simultaneous;
    push(1'b1, 4'd5, 8'h55);
    push(1'b0, 4'd6, 8'h00);
    drive(1'b1, 1'b1, 4'd10, 8'hAA);
    bus.grant = 1'b1;
    #1;
    total++; if (bus.request !== mk(1'b1, 4'd5, 8'h55)) begin bad++; $display("FAIL simul_head got=%h want=%h", bus.request, mk(1'b1, 4'd5, 8'h55)); end
    tick;
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.count !== 3'd2) begin bad++; $display("FAIL simul_count got=%0d want=2", bus.count); end
    total++; if (bus.request !== mk(1'b0, 4'd6, 8'h00)) begin bad++; $display("FAIL simul_next got=%h want=%h", bus.request, mk(1'b0, 4'd6, 8'h00)); end
    tick;
    total++; if (bus.request !== mk(1'b1, 4'd10, 8'hAA)) begin bad++; $display("FAIL simul_tail got=%h want=%h", bus.request, mk(1'b1, 4'd10, 8'hAA)); end
    tick;
    bus.grant = 1'b0;
    #1;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL simul_drained got=%0d want=0", bus.count); end
  endtask

  task automatic test_error;
    bus.grant = 1'b1;
    #1;
    total++; if (bus.err_grant !== 1'b0) begin bad++; $display("FAIL err_before got=%b want=0", bus.err_grant); end
    tick;
    bus.grant = 1'b0;
    #1;
    total++; if (bus.err_grant !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", bus.err_grant); end
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL err_count got=%0d want=0", bus.count); end
    tick;
    total++; if (bus.err_grant !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", bus.err_grant); end
    reset = 1'b0;
    #1;
    total++; if (bus.err_grant !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b want=0", bus.err_grant); end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_bypass;
    logic [13:0] w;
    w = mk(1'b1, 4'd9, 8'h11);
    drive(1'b1, 1'b1, 4'd9, 8'h11);
    bus.grant = 1'b1;
    #1;
`ifdef RR_REQ_QUEUE_BYPASS_EN
    total++; if (bus.request !== w) begin bad++; $display("FAIL bypass_same_cycle got=%h want=%h", bus.request, w); end
    tick;
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    bus.grant = 1'b0;
    #1;
    total++; if (bus.count !== 3'd0) begin bad++; $display("FAIL bypass_count got=%0d want=0", bus.count); end
    total++; if (bus.err_grant !== 1'b0) begin bad++; $display("FAIL bypass_err got=%b want=0", bus.err_grant); end
`else
    total++; if (bus.request !== 14'h0) begin bad++; $display("FAIL nobypass_same_cycle got=%h want=0", bus.request); end
    tick;
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    bus.grant = 1'b0;
    #1;
    total++; if (bus.count !== 3'd1) begin bad++; $display("FAIL nobypass_count got=%0d want=1", bus.count); end
    total++; if (bus.request !== w) begin bad++; $display("FAIL nobypass_next got=%h want=%h", bus.request, w); end
    total++; if (bus.err_grant !== 1'b1) begin bad++; $display("FAIL nobypass_err got=%b want=1", bus.err_grant); end
`endif
  endtask

  initial begin
    test_reset;
    test_order;
    test_full_wrap;
    test_simultaneous;
    test_error;
    test_bypass;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
